param_bounce_counter: RTL and testbench
=======================================

Name: param_bounce_counter

Overview:
- WIDTH-bit bounded up/down counter with runtime-selectable mode: ping-pong, wrap, one-shot or hold.
- Adds runtime step size, parallel load, per-event status pulse, and a range-error flag.
- Drop-in generator for LED sweeps, PWM ramps and test-pattern sequencing in lab top-levels.

Parameters:
- WIDTH, 8, counter/bound/step width (>=2).
- DWELL_CYCLES, 4, endpoint dwell length; used only with PBC_DWELL_EN; >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- enable  in  1  advance counter this cycle
- mode  in  2  0=PINGPONG, 1=WRAP, 2=ONESHOT, 3=HOLD
- step  in  WIDTH  increment magnitude; 0 = no movement
- flip  in  1  invert direction (PINGPONG/WRAP only)
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- load_dir  in  1  direction to load (0=up, 1=down)
- max  in  WIDTH  upper bound, inclusive
- min  in  WIDTH  lower bound, inclusive
- out  out  WIDTH  counter value (registered)
- direction  out  1  0=up, 1=down (registered)
- event_p  out  1  one-cycle pulse: reversal, wrap or one-shot completion on the preceding update
- done  out  1  ONESHOT reached its bound; sticky until load or reset
- range_err  out  1  combinational, max<=min

Behaviour:
- Reset, at posedge clk with rst_n=0:
  - out=min, direction=0, event_p=0, done=0.
  - Dwell state=RUN, dwell counter=0.
  - Reset overrides load and enable.
- Priority per cycle: reset > load > (enable & !range_err & mode!=HOLD) > hold.
- Load:
  - out <= load_val clamped into [min,max]; raw load_val if range_err.
  - direction <= load_dir; done <= 0; event_p <= 0.
  - Load works in any mode and while disabled.
- Advance, out-of-range guard: if out<min, out <= min; if out>max, out <= max. No step applied, no event_p.
- All arithmetic is WIDTH+1 bits; no modular overflow.
- PINGPONG:
  - d' = direction ^ (flip | (out==max & up) | (out==min & down)). Simultaneous flip and bound give a single inversion.
  - out <= d' down ? max(out-step, min) : min(out+step, max).
  - event_p=1 when the inversion came from a bound.
- WRAP:
  - d' = direction ^ flip.
  - Up: if out+step>max, out <= min and event_p=1; else out+step.
  - Down: if out<min+step, out <= max and event_p=1; else out-step.
- ONESHOT:
  - flip ignored.
  - Moves in direction, clamped at the bound.
  - The cycle out reaches the bound: done <= 1, event_p=1.
  - While done=1 the counter freezes until load.
- HOLD, enable=0, or range_err: out and direction unchanged; event_p=0.
- event_p deasserts the cycle after assertion unless a new event occurs.
- Mode change mid-run takes effect next cycle and keeps out/direction. Leaving ONESHOT keeps done until load or reset.
- Latency: inputs sampled at posedge; outputs valid the same edge.

Optional Feature:
- Macro PBC_DWELL_EN.
- Defined: 2-state FSM RUN/DWELL, in PINGPONG only.
  - On a bound-triggered reversal, enter DWELL; counter holds at the bound for DWELL_CYCLES enabled cycles, direction already updated; then return to RUN.
  - event_p pulses on DWELL entry.
  - flip during DWELL aborts the dwell and acts normally that cycle.
  - Load or reset exits to RUN.
- Undefined: no FSM; reversal is immediate as described above. DWELL_CYCLES is ignored.

Decomposition:
- Package pbc_pkg:
  - Mode encodings MODE_PINGPONG/WRAP/ONESHOT/HOLD.
  - Direction constants DIR_UP=0, DIR_DOWN=1.
  - Dwell state encoding.
- Sub-module pbc_next_value (combinational): takes out, direction, step, min, max, mode, flip; returns next out, next direction, and bound/wrap hit. The top level holds registers, load/priority logic, done, and the dwell FSM.

Test Plan (WIDTH=8):
- PINGPONG, min=2, max=5, step=1, enable=1 after reset: out 2,3,4,5,4,3,2,3; event_p after reaching 5 and 2; direction toggles there.
- PINGPONG, min=0, max=10, step=4: out 0,4,8,10,6,2,0,4 (clamped at the ends). Flip asserted at out=4 going up → next out 0.
- WRAP up, min=10, max=20, step=3: 10,13,16,19,10, with event_p on the wrap. Same setup down from 11: 11,20,17.
- ONESHOT down from load 9, min=3, step=2: 9,7,5,3, done=1, then frozen. Load 8 → done=0 and counting resumes.
- max=min=7 → range_err=1 and out frozen. Load 200 with min=0, max=50 → out=50. Reset mid-count → out=min, direction=0 next edge.
- With PBC_DWELL_EN and DWELL_CYCLES=3, PINGPONG 0..3: out 0,1,2,3,3,3,3,2.

Source files
------------

// File: rtl/pbc_pkg.sv
// Shared encodings for param_bounce_counter: mode, direction and dwell-state values.
package pbc_pkg;

    typedef enum logic [1:0] {
        MODE_PINGPONG = 2'd0,
        MODE_WRAP     = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_HOLD     = 2'd3
    } pbc_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DWELL = 1'b1
    } pbc_dwell_e;

endpackage

// File: rtl/pbc_next_value.sv
// Combinational next-step calculator for param_bounce_counter.
// Produces the next count value, next direction, and a flag for a bound reversal,
// a wrap, or a one-shot reaching its bound. Arithmetic is WIDTH+1 bits so that
// stepping past either end never wraps modulo 2^WIDTH.
module pbc_next_value
    import pbc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_out,
    input  logic             cur_dir,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  pbc_mode_e        mode,
    input  logic             flip,
    output logic [WIDTH-1:0] nxt_out,
    output logic             nxt_dir,
    output logic             hit
);

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_floor;
    logic             up_over;
    logic             dn_under;
    logic [WIDTH-1:0] up_sat;
    logic [WIDTH-1:0] dn_sat;
    logic             bound_rev;

    // Saturating up/down candidates and the per-mode selection.
    always_comb begin
        up_sum    = {1'b0, cur_out} + {1'b0, step};
        dn_floor  = {1'b0, min} + {1'b0, step};
        up_over   = up_sum > {1'b0, max};
        dn_under  = {1'b0, cur_out} < dn_floor;
        up_sat    = up_over  ? max : up_sum[WIDTH-1:0];
        dn_sat    = dn_under ? min : (cur_out - step);
        bound_rev = ((cur_out == max) && (cur_dir == DIR_UP)) ||
                    ((cur_out == min) && (cur_dir == DIR_DOWN));

        nxt_out = cur_out;
        nxt_dir = cur_dir;
        hit     = 1'b0;

        if (cur_out < min) begin
            nxt_out = min;
        end else if (cur_out > max) begin
            nxt_out = max;
        end else begin
            unique case (mode)
                MODE_PINGPONG: begin
                    // flip and a bound arriving together still give one inversion
                    nxt_dir = cur_dir ^ (flip | bound_rev);
                    nxt_out = (nxt_dir == DIR_DOWN) ? dn_sat : up_sat;
                    hit     = bound_rev;
                end
                MODE_WRAP: begin
                    nxt_dir = cur_dir ^ flip;
                    if (nxt_dir == DIR_UP) begin
                        nxt_out = up_over ? min : up_sum[WIDTH-1:0];
                        hit     = up_over;
                    end else begin
                        nxt_out = dn_under ? max : (cur_out - step);
                        hit     = dn_under;
                    end
                end
                MODE_ONESHOT: begin
                    if (cur_dir == DIR_UP) begin
                        nxt_out = up_sat;
                        hit     = (up_sat == max);
                    end else begin
                        nxt_out = dn_sat;
                        hit     = (dn_sat == min);
                    end
                end
                default: begin
                    nxt_out = cur_out;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_bounce_counter.sv
// Bounded up/down counter with ping-pong, wrap, one-shot and hold modes,
// runtime step, parallel load, event pulse and range-error flag.
// Optional build macro PBC_DWELL_EN adds a RUN/DWELL pause at ping-pong reversals.
module param_bounce_counter
    import pbc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic             flip,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_dir,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             event_p,
    output logic             done,
    output logic             range_err
);

    if (WIDTH < 2 || DWELL_CYCLES < 1) begin : g_bad_params
        $error("param_bounce_counter: WIDTH must be >=2 and DWELL_CYCLES >=1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             event_q, event_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] nv_out;
    logic             nv_dir;
    logic             nv_hit;
    logic [WIDTH-1:0] load_clamped;
    logic             advance;
    logic             take_next;
    pbc_mode_e        mode_e;

`ifdef PBC_DWELL_EN
    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
    pbc_dwell_e       dwell_q, dwell_d;
    logic [DW-1:0]    cnt_q, cnt_d;
`endif

    assign mode_e    = pbc_mode_e'(mode);
    assign range_err = (max <= min);
    assign advance   = enable && !range_err && (mode_e != MODE_HOLD) &&
                       !((mode_e == MODE_ONESHOT) && done_q);

    pbc_next_value #(.WIDTH(WIDTH)) u_next (
        .cur_out (out_q),
        .cur_dir (dir_q),
        .step    (step),
        .min     (min),
        .max     (max),
        .mode    (mode_e),
        .flip    (flip),
        .nxt_out (nv_out),
        .nxt_dir (nv_dir),
        .hit     (nv_hit)
    );

    // Load clamping, priority resolution and (optionally) the dwell state machine.
    always_comb begin
        if (range_err)           load_clamped = load_val;
        else if (load_val < min) load_clamped = min;
        else if (load_val > max) load_clamped = max;
        else                     load_clamped = load_val;

        out_d     = out_q;
        dir_d     = dir_q;
        event_d   = 1'b0;
        done_d    = done_q;
        take_next = 1'b0;
`ifdef PBC_DWELL_EN
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
`endif

        if (load) begin
            out_d  = load_clamped;
            dir_d  = load_dir;
            done_d = 1'b0;
`ifdef PBC_DWELL_EN
            dwell_d = ST_RUN;
            cnt_d   = '0;
`endif
        end else if (advance) begin
`ifdef PBC_DWELL_EN
            // The reversal cycle counts as the first held cycle; a flip or a mode
            // change aborts the dwell and the step is taken normally.
            if ((dwell_q == ST_DWELL) && (mode_e == MODE_PINGPONG) && !flip &&
                (32'(cnt_q) < 32'(DWELL_CYCLES))) begin
                cnt_d = cnt_q + DW'(1);
            end else begin
                take_next = 1'b1;
            end
`else
            take_next = 1'b1;
`endif
        end

        if (take_next) begin
            out_d   = nv_out;
            dir_d   = nv_dir;
            event_d = nv_hit;
            if ((mode_e == MODE_ONESHOT) && nv_hit) done_d = 1'b1;
`ifdef PBC_DWELL_EN
            dwell_d = ST_RUN;
            cnt_d   = '0;
            if ((mode_e == MODE_PINGPONG) && nv_hit) begin
                out_d   = out_q;
                dwell_d = ST_DWELL;
                cnt_d   = DW'(1);
            end
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= min;
            dir_q   <= DIR_UP;
            event_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef PBC_DWELL_EN
            dwell_q <= ST_RUN;
            cnt_q   <= '0;
`endif
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            event_q <= event_d;
            done_q  <= done_d;
`ifdef PBC_DWELL_EN
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign out       = out_q;
    assign direction = dir_q;
    assign event_p   = event_q;
    assign done      = done_q;

endmodule

// File: tb/tb_param_bounce_counter.sv
// Directed self-checking bench for param_bounce_counter (WIDTH=8, DWELL_CYCLES=3).
module tb_param_bounce_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] step = 8'd0;
    logic       flip = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       load_dir = 1'b0;
    logic [7:0] max = 8'd0;
    logic [7:0] min = 8'd0;
    logic [7:0] out;
    logic       direction;
    logic       event_p;
    logic       done;
    logic       range_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_bounce_counter #(.WIDTH(8), .DWELL_CYCLES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .step      (step),
        .flip      (flip),
        .load      (load),
        .load_val  (load_val),
        .load_dir  (load_dir),
        .max       (max),
        .min       (min),
        .out       (out),
        .direction (direction),
        .event_p   (event_p),
        .done      (done),
        .range_err (range_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mode = 2'd0; min = 8'd2; max = 8'd5; step = 8'd1; enable = 1'b1;
        load = 1'b1; load_val = 8'd4; load_dir = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++; if (out !== 8'd2) begin errors++; $display("FAIL reset_out got=%0d exp=2", out); end
        checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_dir got=%0b exp=0", direction); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL reset_event got=%0b exp=0", event_p); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got=%0b exp=0", range_err); end
        rst_n = 1'b1; load = 1'b0;
    endtask

    task automatic test_pingpong_small();
        logic [7:0] eo [7];
        logic       ee [7];
        logic       ed [7];
        eo = '{8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd3};
        ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (out !== eo[i]) begin errors++; $display("FAIL pp_small_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
            checks++; if (event_p !== ee[i]) begin errors++; $display("FAIL pp_small_event[%0d] got=%0b exp=%0b", i, event_p, ee[i]); end
            checks++; if (direction !== ed[i]) begin errors++; $display("FAIL pp_small_dir[%0d] got=%0b exp=%0b", i, direction, ed[i]); end
        end
    endtask

    task automatic test_pingpong_step();
        logic [7:0] eo [7];
        logic       ee [7];
        eo = '{8'd4, 8'd8, 8'd10, 8'd6, 8'd2, 8'd0, 8'd4};
        ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        enable = 1'b0; mode = 2'd0; min = 8'd0; max = 8'd10; step = 8'd4;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (out !== eo[i]) begin errors++; $display("FAIL pp_step_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
            checks++; if (event_p !== ee[i]) begin errors++; $display("FAIL pp_step_event[%0d] got=%0b exp=%0b", i, event_p, ee[i]); end
        end
        flip = 1'b1;
        tick();
        flip = 1'b0;
        checks++; if (out !== 8'd0) begin errors++; $display("FAIL pp_flip_out got=%0d exp=0", out); end
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL pp_flip_dir got=%0b exp=1", direction); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL pp_flip_event got=%0b exp=0", event_p); end
    endtask

    task automatic test_wrap();
        logic [7:0] eo [4];
        logic       ee [4];
        eo = '{8'd13, 8'd16, 8'd19, 8'd10};
        ee = '{1'b0, 1'b0, 1'b0, 1'b1};
        enable = 1'b0; mode = 2'd1; min = 8'd10; max = 8'd20; step = 8'd3;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out !== eo[i]) begin errors++; $display("FAIL wrap_up_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
            checks++; if (event_p !== ee[i]) begin errors++; $display("FAIL wrap_up_event[%0d] got=%0b exp=%0b", i, event_p, ee[i]); end
        end
        load = 1'b1; load_val = 8'd11; load_dir = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (out !== 8'd11) begin errors++; $display("FAIL wrap_load_out got=%0d exp=11", out); end
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL wrap_load_dir got=%0b exp=1", direction); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL wrap_load_event got=%0b exp=0", event_p); end
        tick();
        checks++; if (out !== 8'd20) begin errors++; $display("FAIL wrap_dn_out0 got=%0d exp=20", out); end
        checks++; if (event_p !== 1'b1) begin errors++; $display("FAIL wrap_dn_event0 got=%0b exp=1", event_p); end
        tick();
        checks++; if (out !== 8'd17) begin errors++; $display("FAIL wrap_dn_out1 got=%0d exp=17", out); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL wrap_dn_event1 got=%0b exp=0", event_p); end
    endtask

    task automatic test_oneshot();
        logic [7:0] eo [3];
        logic       ee [3];
        eo = '{8'd7, 8'd5, 8'd3};
        ee = '{1'b0, 1'b0, 1'b1};
        mode = 2'd2; min = 8'd3; max = 8'd20; step = 8'd2; enable = 1'b1;
        load = 1'b1; load_val = 8'd9; load_dir = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (out !== 8'd9) begin errors++; $display("FAIL os_load_out got=%0d exp=9", out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out !== eo[i]) begin errors++; $display("FAIL os_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
            checks++; if (event_p !== ee[i]) begin errors++; $display("FAIL os_event[%0d] got=%0b exp=%0b", i, event_p, ee[i]); end
            checks++; if (done !== ee[i]) begin errors++; $display("FAIL os_done[%0d] got=%0b exp=%0b", i, done, ee[i]); end
        end
        tick();
        checks++; if (out !== 8'd3) begin errors++; $display("FAIL os_frozen_out got=%0d exp=3", out); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL os_frozen_event got=%0b exp=0", event_p); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL os_sticky_done got=%0b exp=1", done); end
        load = 1'b1; load_val = 8'd8; load_dir = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (out !== 8'd8) begin errors++; $display("FAIL os_reload_out got=%0d exp=8", out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL os_reload_done got=%0b exp=0", done); end
        tick();
        checks++; if (out !== 8'd6) begin errors++; $display("FAIL os_resume_out got=%0d exp=6", out); end
    endtask

    task automatic test_range();
        mode = 2'd0; enable = 1'b1; min = 8'd7; max = 8'd7;
        #1;
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_eq got=%0b exp=1", range_err); end
        tick();
        checks++; if (out !== 8'd6) begin errors++; $display("FAIL range_frozen_out got=%0d exp=6", out); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL range_frozen_event got=%0b exp=0", event_p); end
        min = 8'd9; max = 8'd3;
        #1;
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_inv got=%0b exp=1", range_err); end
        load = 1'b1; load_val = 8'd100; load_dir = 1'b0;
        tick();
        load = 1'b0;
        checks++; if (out !== 8'd100) begin errors++; $display("FAIL range_raw_load got=%0d exp=100", out); end
        min = 8'd0; max = 8'd50;
        tick();
        checks++; if (out !== 8'd50) begin errors++; $display("FAIL guard_out got=%0d exp=50", out); end
        checks++; if (event_p !== 1'b0) begin errors++; $display("FAIL guard_event got=%0b exp=0", event_p); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_ok got=%0b exp=0", range_err); end
        enable = 1'b0;
        load = 1'b1; load_val = 8'd200;
        tick();
        checks++; if (out !== 8'd50) begin errors++; $display("FAIL load_clamp_hi got=%0d exp=50", out); end
        min = 8'd5; load_val = 8'd1;
        tick();
        load = 1'b0;
        checks++; if (out !== 8'd5) begin errors++; $display("FAIL load_clamp_lo got=%0d exp=5", out); end
    endtask

    task automatic test_hold();
        mode = 2'd3; enable = 1'b1; step = 8'd2;
        tick();
        checks++; if (out !== 8'd5) begin errors++; $display("FAIL hold_mode_out got=%0d exp=5", out); end
        mode = 2'd0; enable = 1'b0;
        tick();
        checks++; if (out !== 8'd5) begin errors++; $display("FAIL disabled_out got=%0d exp=5", out); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0; min = 8'd0; max = 8'd50; step = 8'd5; enable = 1'b1;
        load = 1'b1; load_val = 8'd20; load_dir = 1'b0;
        tick();
        load = 1'b0;
        tick();
        checks++; if (out !== 8'd25) begin errors++; $display("FAIL mid_count_out got=%0d exp=25", out); end
        rst_n = 1'b0; load = 1'b1; load_val = 8'd40; load_dir = 1'b1;
        tick();
        rst_n = 1'b1; load = 1'b0;
        checks++; if (out !== 8'd0) begin errors++; $display("FAIL mid_reset_out got=%0d exp=0", out); end
        checks++; if (direction !== 1'b0) begin errors++; $display("FAIL mid_reset_dir got=%0b exp=0", direction); end
    endtask

`ifdef PBC_DWELL_EN
    task automatic test_dwell();
        logic [7:0] eo [7];
        logic       ee [7];
        logic       ed [7];
        eo = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2};
        ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        enable = 1'b0; mode = 2'd0; min = 8'd0; max = 8'd3; step = 8'd1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (out !== eo[i]) begin errors++; $display("FAIL dwell_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
            checks++; if (event_p !== ee[i]) begin errors++; $display("FAIL dwell_event[%0d] got=%0b exp=%0b", i, event_p, ee[i]); end
            checks++; if (direction !== ed[i]) begin errors++; $display("FAIL dwell_dir[%0d] got=%0b exp=%0b", i, direction, ed[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PBC_DWELL_EN
        test_dwell();
`else
        test_pingpong_small();
        test_pingpong_step();
`endif
        test_wrap();
        test_oneshot();
        test_range();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
